ethernet_smi_controller: RTL
============================

Name: ethernet_smi_controller

Overview:
Sequences complete IEEE 802.3 clause-22 SMI (MDIO) management frames to an external PHY. Takes a read or write request from a host (CPU register block) through a valid/ready handshake and serialises preamble, ST, OP, PHYAD, REGAD, TA and DATA onto mdc/mdio. For reads, it captures the 16-bit register data and returns it. Timing comes from the external SMI clock unit: its one-cycle `finalCycle` strobe (every 50 clk at 100 MHz) drives the `tick` input, and each tick is one MDC half-period.

Parameters:
PREAMBLE_BITS, 32, number of leading '1' bits per frame; legal range 0..32.

Ports:
clk  input  1  system clock (100 MHz)
reset  input  1  synchronous, active-low reset: state is cleared on a clk edge while reset==0
tick  input  1  one-cycle strobe from the SMI clock unit; each tick advances MDC by one half-period
req_valid  input  1  host request valid
req_ready  output  1  high only in IDLE; a request is accepted when req_valid&&req_ready
req_read  input  1  1=read (OP=10), 0=write (OP=01)
req_phy  input  5  PHY address
req_reg  input  5  register address
req_wdata  input  16  write data; ignored for reads
rsp_valid  output  1  one-cycle pulse at frame completion
rsp_rdata  output  16  read data; holds until the next response; 0x0000 after a write
rsp_error  output  1  valid with rsp_valid; 1 = read turnaround bit 2 sampled as 1 (no PHY response)
mdc  output  1  management clock
mdio_out  output  1  serial data out
mdio_oe  output  1  output enable for the tristate pad
mdio_in  input  1  serial data in, already synchronised at the pad level

Behaviour:
- Reset values (reset==0 at clk edge): state=IDLE, mdc=0, mdio_out=1, mdio_oe=0, req_ready=0 during reset, rsp_valid=0, rsp_rdata=0, rsp_error=0.
- States: IDLE, PRE, HDR, TA, DATA, END. A bit counter (6 bit) and a 16-bit shift register serve all states.
- IDLE: req_ready=1, mdc=0, oe=0.
  - On accept, latch the request fields and go to PRE (or to HDR if PREAMBLE_BITS==0).
  - Ticks in IDLE are ignored.
  - If a tick coincides with the accept, it is not consumed; the frame starts on the next tick.
- Bit timing: every frame bit takes two ticks.
  - Low-phase tick: mdc<=0, mdio_out/mdio_oe updated for the new bit.
  - High-phase tick: mdc<=1. In read-capture bits, mdio_in is sampled in the same clk cycle as this tick.
- PRE: PREAMBLE_BITS bits of 1, oe=1.
- HDR: 14 bits, MSB first: ST=01, OP, PHYAD[4:0], REGAD[4:0]; oe=1.
- TA, write: drive 1 then 0, oe=1.
- TA, read: oe=0 for both bits. The mdio_in value sampled at the second TA bit's high phase sets the error flag (1 = error).
- DATA, write: req_wdata[15:0] MSB first, oe=1.
- DATA, read: oe=0; shift in mdio_in MSB first on each high-phase tick.
  - A read with error still runs all 16 bits.
  - With mdio_in pulled high, rdata=0xFFFF.
- END: on the next tick after the last DATA high phase:
  - mdc<=0, oe<=0, mdio_out<=1.
  - rsp_valid=1 for exactly one clk; update rsp_rdata and rsp_error.
  - Return to IDLE. req_ready rises in the cycle after rsp_valid.
- Frame length: PREAMBLE_BITS+32 bits, which is 2*(PREAMBLE_BITS+32)+1 ticks from the first tick to rsp_valid. The default is 129 ticks (6450 clk with ticks every 50 clk).
- mdc only changes on tick cycles, so the 50% duty cycle is inherited from the tick rate.
- Reset mid-frame: abort immediately to IDLE with the reset values above. No rsp_valid is generated. The PHY recovers on the next preamble.
- req_valid while busy: ignored (ready=0). The host must hold the request.

Decomposition:
- Package ethernet_smi_pkg holds:
  - state enum;
  - OP constants (SMI_OP_READ=2'b10, SMI_OP_WRITE=2'b01);
  - SMI_ST=2'b01;
  - field widths (PHY 5, REG 5, DATA 16);
  - HDR_BITS=14, TA_BITS=2.
- Ticks come from the existing SMI clock unit, instantiated alongside the controller in the ethernet top; it is not a sub-module.
- An optional sub-module, ethernet_smi_shifter (16-bit load/shift-out/shift-in register with MSB tap), is natural. Otherwise the design is a single module.

Test Plan:
- Write: phy=5, reg=0x1F, wdata=0xA5C3, tick every 50 clk.
  - mdio stream = 32×'1', 01, 01, 00101, 11111, 10, 1010010111000011, with oe=1 throughout.
  - rsp_valid 129 ticks after the first tick; rsp_rdata=0x0000, rsp_error=0.
- Read: phy=1, reg=2, bench PHY model drives 0 on TA2 then 0x1234.
  - oe=0 from TA onward; rsp_rdata=0x1234, rsp_error=0.
- Read with no PHY (mdio_in tied 1): rsp_error=1, rsp_rdata=0xFFFF, frame length unchanged.
- Handshake: second req_valid held during an active frame; req_ready=0 and it is not accepted. It is accepted one cycle after rsp_valid. Also check that an accept coinciding with a tick starts the frame on the following tick.
- Reset: drive reset=0 during read DATA bit 8.
  - Next cycle: mdc=0, oe=0, mdio_out=1, no rsp_valid.
  - A following write completes correctly.
- PREAMBLE_BITS=0 build: a write frame has no preamble and rsp_valid comes 65 ticks after the first tick.

Source files
------------

// File: rtl/ethernet_smi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ethernet_smi_pkg
// Description : Shared types, frame constants and header builder for the
//               clause-22 SMI management controller.
// Revision    : 1.0 - initial release
// ============================================================================
package ethernet_smi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_HDR  = 3'd2,
    ST_TA   = 3'd3,
    ST_DATA = 3'd4,
    ST_END  = 3'd5
  } smiState_t;

  localparam logic [1:0] SMI_OP_READ  = 2'b10;
  localparam logic [1:0] SMI_OP_WRITE = 2'b01;
  localparam logic [1:0] SMI_ST       = 2'b01;

  localparam int PHY_W    = 5;
  localparam int REG_W    = 5;
  localparam int DATA_W   = 16;
  localparam int HDR_BITS = 14;
  localparam int TA_BITS  = 2;

  // ST, OP, PHYAD, REGAD in transmit order (MSB goes out first)
  function automatic logic [HDR_BITS-1:0] smiHeader(
    input logic             isRead,
    input logic [PHY_W-1:0] phyAddr,
    input logic [REG_W-1:0] regAddr
  );
    return {SMI_ST, (isRead ? SMI_OP_READ : SMI_OP_WRITE), phyAddr, regAddr};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ethernet_smi_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : ethernet_smi_controller_if
// Description : Host request/response channel of the SMI controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface ethernet_smi_controller_if;
  import ethernet_smi_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_read;
  logic [PHY_W-1:0]  req_phy;
  logic [REG_W-1:0]  req_reg;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_error;

  modport master (
    output req_valid, req_read, req_phy, req_reg, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error
  );

  modport slave (
    input  req_valid, req_read, req_phy, req_reg, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_error
  );

endinterface
`default_nettype wire

// File: rtl/ethernet_smi_shifter.sv
`default_nettype none
// ============================================================================
// Module      : ethernet_smi_shifter
// Description : Load / shift-left register with MSB tap, used both to
//               serialise write data and to assemble read data.
// Revision    : 1.0 - initial release
// ============================================================================
module ethernet_smi_shifter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] loadData,
  input  logic             shift,
  input  logic             serialIn,
  output logic             msb,
  output logic [WIDTH-1:0] data
);

  logic [WIDTH-1:0] r_data;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_data <= '0;
    end else if (load) begin
      r_data <= loadData;
    end else if (shift) begin
      r_data <= {r_data[WIDTH-2:0], serialIn};
    end
  end

  assign msb  = r_data[WIDTH-1];
  assign data = r_data;

endmodule
`default_nettype wire

// File: rtl/ethernet_smi_controller.sv
`default_nettype none
// ============================================================================
// Module      : ethernet_smi_controller
// Description : Serialises clause-22 SMI read/write frames onto mdc/mdio,
//               one MDC half-period per tick strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module ethernet_smi_controller
  import ethernet_smi_pkg::*;
#(
  parameter int PREAMBLE_BITS = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       tick,
  ethernet_smi_controller_if.slave   host,
  output logic                       mdc,
  output logic                       mdio_out,
  output logic                       mdio_oe,
  input  logic                       mdio_in
);

  localparam logic [5:0] c_PRE_LAST  = (PREAMBLE_BITS == 0) ? 6'd0 : 6'(PREAMBLE_BITS - 1);
  localparam logic [5:0] c_HDR_LAST  = 6'(HDR_BITS - 1);
  localparam logic [5:0] c_TA_LAST   = 6'(TA_BITS - 1);
  localparam logic [5:0] c_DATA_LAST = 6'(DATA_W - 1);

  smiState_t           r_state;
  smiState_t           w_stateNext;
  logic [5:0]          r_cnt;
  logic                r_phase;
  logic                r_read;
  logic                r_taError;
  logic [HDR_BITS-1:0] r_hdr;
  logic                r_mdc;
  logic                r_mdioOut;
  logic                r_mdioOe;
  logic                r_rspValid;
  logic                r_rspError;
  logic [DATA_W-1:0]   r_rspRdata;

  logic                w_accept;
  logic                w_inBitState;
  logic                w_lowTick;
  logic                w_highTick;
  logic                w_lastBit;
  logic                w_bit;
  logic                w_oe;
  logic                w_shMsb;
  logic [DATA_W-1:0]   w_shData;

  // Ready stays low for the response cycle so a held request lands one cycle later
  assign host.req_ready = reset && (r_state == ST_IDLE) && !r_rspValid;
  assign w_accept       = host.req_valid && host.req_ready;
  assign w_inBitState   = (r_state == ST_PRE) || (r_state == ST_HDR) ||
                          (r_state == ST_TA)  || (r_state == ST_DATA);
  assign w_lowTick      = tick && w_inBitState && !r_phase;
  assign w_highTick     = tick && w_inBitState && r_phase;

  ethernet_smi_shifter #(.WIDTH(DATA_W)) u_shifter (
    .clk      (clk),
    .reset    (reset),
    .load     (w_accept),
    .loadData (host.req_read ? '0 : host.req_wdata),
    .shift    (w_highTick && (r_state == ST_DATA)),
    .serialIn (r_read & mdio_in),
    .msb      (w_shMsb),
    .data     (w_shData)
  );

  always_comb begin
    w_stateNext = r_state;
    w_lastBit   = 1'b0;
    w_bit       = 1'b1;
    w_oe        = 1'b1;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_stateNext = (PREAMBLE_BITS == 0) ? ST_HDR : ST_PRE;
      end
      ST_PRE: begin
        w_lastBit = (r_cnt == c_PRE_LAST);
        if (w_highTick && w_lastBit) w_stateNext = ST_HDR;
      end
      ST_HDR: begin
        w_bit     = r_hdr[HDR_BITS-1];
        w_lastBit = (r_cnt == c_HDR_LAST);
        if (w_highTick && w_lastBit) w_stateNext = ST_TA;
      end
      ST_TA: begin
        w_oe      = !r_read;
        w_bit     = r_read || (r_cnt == 6'd0);
        w_lastBit = (r_cnt == c_TA_LAST);
        if (w_highTick && w_lastBit) w_stateNext = ST_DATA;
      end
      ST_DATA: begin
        w_oe      = !r_read;
        w_bit     = r_read || w_shMsb;
        w_lastBit = (r_cnt == c_DATA_LAST);
        if (w_highTick && w_lastBit) w_stateNext = ST_END;
      end
      ST_END: begin
        w_oe = 1'b0;
        if (tick) w_stateNext = ST_IDLE;
      end
      default: w_stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_stateNext;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt      <= '0;
      r_phase    <= 1'b0;
      r_read     <= 1'b0;
      r_taError  <= 1'b0;
      r_hdr      <= '0;
      r_mdc      <= 1'b0;
      r_mdioOut  <= 1'b1;
      r_mdioOe   <= 1'b0;
      r_rspValid <= 1'b0;
      r_rspRdata <= '0;
      r_rspError <= 1'b0;
    end else begin
      r_rspValid <= 1'b0;
      if (w_accept) begin
        r_read    <= host.req_read;
        r_hdr     <= smiHeader(host.req_read, host.req_phy, host.req_reg);
        r_cnt     <= '0;
        r_phase   <= 1'b0;
        r_taError <= 1'b0;
      end
      if (w_lowTick) begin
        r_mdc     <= 1'b0;
        r_mdioOut <= w_bit;
        r_mdioOe  <= w_oe;
        r_phase   <= 1'b1;
      end
      if (w_highTick) begin
        r_mdc   <= 1'b1;
        r_phase <= 1'b0;
        r_cnt   <= w_lastBit ? 6'd0 : r_cnt + 6'd1;
        if (r_state == ST_HDR) r_hdr <= r_hdr << 1;
        // Second turnaround bit: a live PHY pulls mdio low here
        if ((r_state == ST_TA) && (r_cnt == c_TA_LAST) && r_read) r_taError <= mdio_in;
      end
      if ((r_state == ST_END) && tick) begin
        r_mdc      <= 1'b0;
        r_mdioOe   <= 1'b0;
        r_mdioOut  <= 1'b1;
        r_rspValid <= 1'b1;
        r_rspRdata <= r_read ? w_shData : '0;
        r_rspError <= r_read & r_taError;
      end
    end
  end

  assign mdc            = r_mdc;
  assign mdio_out       = r_mdioOut;
  assign mdio_oe        = r_mdioOe;
  assign host.rsp_valid = r_rspValid;
  assign host.rsp_rdata = r_rspRdata;
  assign host.rsp_error = r_rspError;

endmodule
`default_nettype wire
